// File: rtl/prod_accumulator.sv
// Accumulates groups of N unsigned 8-bit products into a saturating ACC_W-bit total.
// Each total is offered on a valid/ready port, and the input is stalled until it is taken.
module prod_accumulator #(
   parameter int unsigned N     = 4,
   parameter int unsigned ACC_W = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [7:0]       in_prod,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_ovf,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int unsigned SUM_W = ACC_W + 1;
   localparam int unsigned CNT_W = $clog2(N + 1);

   typedef enum logic {
      S_ACC  = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [ACC_W-1:0]   r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ovf;
   logic [ACC_W-1:0]   r_out_sum;
   logic               r_out_ovf;

   logic               w_xfer;
   logic               w_last;
   logic [SUM_W-1:0]   w_nxt;
   logic               w_step_ovf;
   logic [ACC_W-1:0]   w_sat;

   // Headroom bit of the widened sum flags saturation for this step.
   assign w_xfer     = in_valid && in_ready && !clr;
   assign w_last     = (r_cnt == CNT_W'(N - 1));
   assign w_nxt      = {1'b0, r_acc} + SUM_W'(in_prod);
   assign w_step_ovf = w_nxt[ACC_W];
   assign w_sat      = w_step_ovf ? {ACC_W{1'b1}} : w_nxt[ACC_W-1:0];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_ACC;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      if (clr) begin
         w_state_nxt = S_ACC;
      end else begin
         case (r_state)
            S_ACC:   if (w_xfer && w_last) w_state_nxt = S_HOLD;
            S_HOLD:  if (out_ready)        w_state_nxt = S_ACC;
            default: w_state_nxt = S_ACC;
         endcase
      end
   end

   // Output decode
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         S_ACC:   in_ready  = 1'b1;
         S_HOLD:  out_valid = 1'b1;
         default: in_ready  = 1'b0;
      endcase
   end

   // Partial sum, group counter, sticky overflow and the held result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc     <= '0;
         r_cnt     <= '0;
         r_ovf     <= 1'b0;
         r_out_sum <= '0;
         r_out_ovf <= 1'b0;
      end else if (clr) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (w_xfer) begin
         if (w_last) begin
            r_out_sum <= w_sat;
            r_out_ovf <= r_ovf | w_step_ovf;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
         end else begin
            r_acc <= w_sat;
            r_cnt <= r_cnt + CNT_W'(1);
            r_ovf <= r_ovf | w_step_ovf;
         end
      end
   end

   assign out_sum = r_out_sum;
   assign out_ovf = r_out_ovf;

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed self-checking bench for prod_accumulator: three instances (N4/W10, N4/W8, N1/W10)
// share one stimulus stream; each scenario starts from reset and checks only the instance it targets.
module tb_prod_accumulator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr;
   logic [7:0] in_prod;
   logic       in_valid;
   logic       out_ready;

   logic       a_in_ready, a_out_ovf, a_out_valid;
   logic [9:0] a_out_sum;
   logic       b_in_ready, b_out_ovf, b_out_valid;
   logic [7:0] b_out_sum;
   logic       c_in_ready, c_out_ovf, c_out_valid;
   logic [9:0] c_out_sum;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   prod_accumulator #(.N(4), .ACC_W(10)) u_a (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_prod(in_prod), .in_valid(in_valid),
      .in_ready(a_in_ready), .out_sum(a_out_sum), .out_ovf(a_out_ovf),
      .out_valid(a_out_valid), .out_ready(out_ready)
   );

   prod_accumulator #(.N(4), .ACC_W(8)) u_b (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_prod(in_prod), .in_valid(in_valid),
      .in_ready(b_in_ready), .out_sum(b_out_sum), .out_ovf(b_out_ovf),
      .out_valid(b_out_valid), .out_ready(out_ready)
   );

   prod_accumulator #(.N(1), .ACC_W(10)) u_c (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_prod(in_prod), .in_valid(in_valid),
      .in_ready(c_in_ready), .out_sum(c_out_sum), .out_ovf(c_out_ovf),
      .out_valid(c_out_valid), .out_ready(out_ready)
   );

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      clr      = 1'b0;
      in_valid = 1'b0;
      in_prod  = 8'd0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic feed1(input logic [7:0] p);
      in_prod  = p;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic feed4(input logic [7:0] p0, input logic [7:0] p1,
                        input logic [7:0] p2, input logic [7:0] p3);
      feed1(p0);
      feed1(p1);
      feed1(p2);
      feed1(p3);
   endtask

   initial begin
      // Reset values, with a product presented that must be ignored
      rst_n     = 1'b0;
      clr       = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_prod   = 8'd99;
      #2;
      check("rst_valid", 32'(a_out_valid), 0);
      check("rst_sum",   32'(a_out_sum),   0);
      check("rst_ovf",   32'(a_out_ovf),   0);
      check("rst_ready", 32'(a_in_ready),  1);
      step();
      step();
      rst_n    = 1'b1;
      in_valid = 1'b0;

      // Back-to-back group 3,5,7,225 with out_ready=1
      feed4(8'd3, 8'd5, 8'd7, 8'd225);
      check("t1_valid", 32'(a_out_valid), 1);
      check("t1_sum",   32'(a_out_sum),   240);
      check("t1_ovf",   32'(a_out_ovf),   0);
      check("t1_ready", 32'(a_in_ready),  0);
      in_prod  = 8'd1;
      in_valid = 1'b1;
      step();
      check("t1_valid_1cyc", 32'(a_out_valid), 0);
      check("t1_ready_back", 32'(a_in_ready),  1);
      feed4(8'd1, 8'd1, 8'd1, 8'd1);
      check("t1_next_valid", 32'(a_out_valid), 1);
      check("t1_next_sum",   32'(a_out_sum),   4);

      // Stall with out_ready low for 5 cycles
      do_reset();
      out_ready = 1'b0;
      feed4(8'd3, 8'd5, 8'd7, 8'd225);
      in_prod  = 8'd9;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("t2_stall_sum",   32'(a_out_sum),   240);
         check("t2_stall_valid", 32'(a_out_valid), 1);
         check("t2_stall_ready", 32'(a_in_ready),  0);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      check("t2_hs_valid", 32'(a_out_valid), 0);
      check("t2_hs_ready", 32'(a_in_ready),  1);
      feed4(8'd1, 8'd1, 8'd1, 8'd1);
      check("t2_next_valid", 32'(a_out_valid), 1);
      check("t2_next_sum",   32'(a_out_sum),   4);

      // Saturation and sticky overflow on the 8-bit instance
      do_reset();
      out_ready = 1'b1;
      feed4(8'd200, 8'd100, 8'd0, 8'd0);
      check("t3_sat_valid", 32'(b_out_valid), 1);
      check("t3_sat_sum",   32'(b_out_sum),   255);
      check("t3_sat_ovf",   32'(b_out_ovf),   1);
      step();
      feed4(8'd1, 8'd2, 8'd3, 8'd4);
      check("t3_clr_valid", 32'(b_out_valid), 1);
      check("t3_clr_sum",   32'(b_out_sum),   10);
      check("t3_clr_ovf",   32'(b_out_ovf),   0);

      // Synchronous clear mid-group discards the concurrent product
      do_reset();
      out_ready = 1'b0;
      feed1(8'd50);
      feed1(8'd60);
      clr      = 1'b1;
      in_prod  = 8'd70;
      in_valid = 1'b1;
      step();
      clr      = 1'b0;
      in_valid = 1'b0;
      check("t4_clr_ready", 32'(a_in_ready), 1);
      feed4(8'd1, 8'd2, 8'd3, 8'd4);
      check("t4_sum",   32'(a_out_sum),   10);
      check("t4_valid", 32'(a_out_valid), 1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("t4_hold_clr_valid", 32'(a_out_valid), 0);
      check("t4_hold_clr_ready", 32'(a_in_ready),  1);

      // Asynchronous reset in HOLD, then mid-group
      do_reset();
      out_ready = 1'b0;
      feed4(8'd3, 8'd5, 8'd7, 8'd225);
      #2 rst_n = 1'b0;
      #1;
      check("t5_hold_rst_valid", 32'(a_out_valid), 0);
      check("t5_hold_rst_sum",   32'(a_out_sum),   0);
      check("t5_hold_rst_ready", 32'(a_in_ready),  1);
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      feed1(8'd9);
      feed1(8'd9);
      #2 rst_n = 1'b0;
      #1;
      check("t5_mid_rst_valid", 32'(a_out_valid), 0);
      check("t5_mid_rst_ovf",   32'(a_out_ovf),   0);
      #2 rst_n = 1'b1;
      step();
      feed4(8'd9, 8'd9, 8'd9, 8'd9);
      check("t5_after_valid", 32'(a_out_valid), 1);
      check("t5_after_sum",   32'(a_out_sum),   36);

      // N=1: every product is a result, one accepted every 2 cycles
      do_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_prod   = 8'd0;
      step();
      check("t6_r0_valid", 32'(c_out_valid), 1);
      check("t6_r0_sum",   32'(c_out_sum),   0);
      check("t6_r0_ready", 32'(c_in_ready),  0);
      in_prod = 8'd255;
      step();
      check("t6_gap0_valid", 32'(c_out_valid), 0);
      step();
      check("t6_r1_valid", 32'(c_out_valid), 1);
      check("t6_r1_sum",   32'(c_out_sum),   255);
      check("t6_r1_ovf",   32'(c_out_ovf),   0);
      in_prod = 8'd17;
      step();
      check("t6_gap1_valid", 32'(c_out_valid), 0);
      step();
      check("t6_r2_valid", 32'(c_out_valid), 1);
      check("t6_r2_sum",   32'(c_out_sum),   17);
      in_valid = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/prod_accumulator.md
# prod_accumulator

- Sequential accumulator directly downstream of the 4x4 unsigned multiplier; consumes its 8-bit products.
- Sums each group of N consecutive products and presents the total on a valid/ready output port.
- Stalls the upstream stage while a finished total is waiting to be taken.
- Forms the accumulate half of the team's multiply-accumulate datapath.

## Interface
Parameters:
- N, 4, number of products summed per result; legal range 1..255.
- ACC_W, 10, accumulator and result width; legal range 8..16. Saturates if too narrow.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear; drops the partial sum and any pending result.
- in_prod  input  8  unsigned product from the multiplier.
- in_valid  input  1  in_prod is valid this cycle.
- in_ready  output  1  block accepts in_prod this cycle.
- out_sum  output  ACC_W  accumulated total of N products.
- out_ovf  output  1  saturation occurred in this result.
- out_valid  output  1  out_sum/out_ovf hold a result.
- out_ready  input  1  downstream takes the result this cycle.

## Operation
- States: ACC (collecting products) and HOLD (result pending). Reset state is ACC.
- in_ready = (state==ACC), combinational from state only. out_valid = (state==HOLD), registered.
- Input transfer = in_valid && in_ready && !clr.
- On each transfer in ACC:
  - Compute nxt = acc + in_prod, zero-extended to ACC_W+1 bits.
  - If nxt > 2^ACC_W-1, saturate to 2^ACC_W-1 and set the sticky ovf bit.
  - Increment cnt (width: smallest holding N).
- When the transfer is the Nth (cnt==N-1):
  - Load out_sum with the saturated nxt and out_ovf with the sticky ovf including this step.
  - Clear acc, cnt and ovf; go to HOLD.
- HOLD:
  - in_ready=0; out_sum and out_ovf stay stable.
  - Output transfer is out_valid && out_ready; it returns the block to ACC.
- clr (any state, highest priority below reset):
  - Next edge sets acc=0, cnt=0, ovf=0 and state=ACC, so out_valid=0.
  - A product presented in the same cycle is discarded.
  - Any pending result is lost.
- N=1: every accepted product becomes a result unchanged, except saturation when ACC_W=8 cannot occur.
- Arithmetic is unsigned throughout. No rounding, no wrap: saturation is the only overflow behaviour.

## Timing
- Reset values: state=ACC, acc=0, cnt=0, ovf=0, out_sum=0, out_ovf=0, out_valid=0.
  - in_ready reads 1 while in reset, but transfers are ignored until rst_n deasserts.
- Reset asserted mid-group or in HOLD aborts immediately and asynchronously. All outputs take their reset values.
- Latency: out_valid rises on the edge that captures the Nth product, i.e. 1 cycle after that transfer.
- Throughput: at most one product per cycle in ACC.
  - Minimum period per result is N+1 cycles: N transfers plus 1 HOLD cycle with immediate out_ready.
- in_ready deasserts in the same cycle out_valid asserts. It reasserts the cycle after the output handshake.
- out_ready held low stalls indefinitely with out_sum stable. in_valid during the stall is not accepted.
- Gaps in in_valid are allowed: cnt and acc hold their values.
- out_ready while out_valid=0 has no effect.

## Test plan
- N=4, ACC_W=10, back-to-back products 3,5,7,225 with out_ready=1:
  - out_valid=1 for exactly 1 cycle after the 4th transfer, out_sum=240, out_ovf=0.
  - in_ready low that cycle; next group accepted the following cycle.
- Same stimulus with out_ready=0 for 5 cycles after out_valid rises:
  - out_sum=240 stable and in_ready=0 for all 5 cycles.
  - Single handshake, then ACC; the next group 1,1,1,1 gives 4.
- ACC_W=8, N=4, products 200,100,0,0:
  - out_sum=255, out_ovf=1.
  - Next group 1,2,3,4 gives out_sum=10, out_ovf=0 (sticky bit cleared).
- Products 50,60, then clr pulsed together with in_valid carrying 70, then 1,2,3,4:
  - 70 is discarded; result out_sum=10.
  - clr pulsed during HOLD drops out_valid the next cycle.
- rst_n pulsed low asynchronously after 2 products:
  - All outputs go to reset values immediately.
  - After release, 4 products of 9 give out_sum=36.
- N=1, products 0, 255, 17 with out_ready=1:
  - Results 0, 255, 17, each 1 cycle after its transfer.
  - One accepted product every 2 cycles.
